booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
Shares one combinational 4-bit signed modified-Booth multiplier (mbooth4bit, ports a, b, p) between NREQ requesters.
- Each requester presents a signed 4-bit operand pair with a valid/ready handshake.
- A round-robin FSM grants one requester at a time, registers its operands into the multiplier, and captures the product.
- The product is returned on a single response channel tagged with the requester id.
- Sits between the multiplier datapath and the client blocks that need occasional signed 4x4 multiplies.

Parameters:
NREQ, 2, number of requesters (legal values 2..4)
IDW, 2, width of requester id (must satisfy 2**IDW >= NREQ)
CNTW, 16, width of the completed-operation counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_a  in  4*NREQ  signed multiplicand; slice i = bits [4i+3:4i]
req_b  in  4*NREQ  signed multiplier; slice i = bits [4i+3:4i]
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  index of the requester that owns rsp_p
rsp_p  out  8  signed product, two's complement
busy  out  1  high when state != IDLE
op_count  out  CNTW  number of completed responses; wraps modulo 2**CNTW

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rsp_valid=0, rsp_id=0, rsp_p=0, op_count=0, operand registers=0, last_grant=NREQ-1 (requester 0 has first priority). rst overrides everything, including mid-MUL or mid-HOLD; an in-flight operation is dropped with no response.
- States: IDLE, MUL, HOLD.
- IDLE:
  - grant = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready[grant]=1 combinationally; all other bits 0. req_ready is all-zero outside IDLE or when no valid is high.
  - On an edge with any valid: latch op_a/op_b from the granted slices, latch id, set last_grant=grant, go to MUL.
- MUL: op_a/op_b drive mbooth4bit. At the next edge: rsp_p <= p, rsp_id <= latched id, rsp_valid <= 1, go to HOLD.
- HOLD: rsp_valid=1; rsp_p and rsp_id stay stable until handshake. On an edge with rsp_ready=1: rsp_valid <= 0, op_count <= op_count+1, go to IDLE.
- Latency: accept edge E0; rsp_valid high in the cycle after E0+1.
- Throughput: with rsp_ready held high, 1 result per 3 cycles (IDLE, MUL, HOLD).
- Requesters must hold operands stable while valid until accepted. Deasserting valid before acceptance is legal: the grant is recomputed each IDLE cycle.
- Fairness: two continuously valid requesters alternate 0, 1, 0, 1, ...
- Arithmetic: operands are signed 4-bit (-8..7); product range -56..64; 8-bit two's complement with no overflow.
- op_count wraps from 2**CNTW-1 to 0 silently.

Decomposition:
- Shared package: state enum (IDLE=2'd0, MUL=2'd1, HOLD=2'd2), PROD_W=8, OP_W=4.
- Sub-modules:
  - mbooth4bit, instantiated unchanged.
  - rr_pick: combinational round-robin selector with inputs valid vector and last_grant, outputs grant index and any_valid.

Test Plan:
1. Reset then single request: req0 a=4'b1001 (-7), b=4'b0001 (1), rsp_ready=1 -> req_ready[0] high in the first cycle; rsp_valid two edges later with rsp_p=8'hF9, rsp_id=0; op_count=1.
2. Contention: req0 (5, -8) and req1 (6, -6) both valid continuously -> req0 served first with rsp_p=8'hD8 id 0; then req1 with rsp_p=8'hDC id 1; then alternation continues.
3. Backpressure: req1 (-1, -1) with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_p=8'h01 stable, req_ready all-zero, busy=1; raise rsp_ready -> one handshake, op_count increments exactly once.
4. Extremes: (-8, -8) -> 8'h40; (7, -8) -> 8'hC8; (-3, -1) -> 8'h03.
5. Reset mid-operation: assert rst while in MUL -> next cycle rsp_valid=0, state IDLE, op_count unchanged, req0 regains first priority.
6. Counter wrap with CNTW=2: complete 5 operations -> op_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/booth_mult_arbiter_pkg.sv
// Shared definitions for the Booth multiplier arbiter: controller states
// and the operand/product widths of the shared 4x4 signed multiplier.
package booth_mult_arbiter_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/booth_mult_arbiter_rr_pick.sv
// Round-robin selector: starting just after the last granted requester and
// wrapping modulo NREQ, picks the first requester whose valid bit is set.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  last_grant,
   output logic [IDW-1:0]  grant,
   output logic            any_valid
);

   // Scan priority offsets 1..NREQ; the first valid requester found wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!any_valid && valid[i] &&
                (((int'(last_grant) + k) % NREQ) == i)) begin
               grant     = IDW'(i);
               any_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mbooth4bit.sv
// Combinational 4-bit signed radix-4 (modified) Booth multiplier.
// Two Booth digits in -2..+2 are recoded from the multiplier; each selects
// a sign-extended partial product of the multiplicand, and the second one
// is weighted by four before the final add. The 8-bit result cannot
// overflow because the product range is -56..64.
module mbooth4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic signed [7:0] a_ext;
   logic        [4:0] b_ext;
   logic signed [7:0] pp0;
   logic signed [7:0] pp1;

   // Map one overlapping bit triplet of the multiplier to its Booth digit
   // and return digit * m.
   function automatic logic signed [7:0] booth_pp(input logic [2:0] trip,
                                                  input logic signed [7:0] m);
      logic signed [7:0] r;
      case (trip)
         3'b001, 3'b010: r = m;
         3'b011:         r = m <<< 1;
         3'b100:         r = -(m <<< 1);
         3'b101, 3'b110: r = -m;
         default:        r = '0;
      endcase
      return r;
   endfunction

   assign a_ext = {{4{a[3]}}, a};
   assign b_ext = {b, 1'b0};

   assign pp0 = booth_pp(b_ext[2:0], a_ext);
   assign pp1 = booth_pp(b_ext[4:2], a_ext);

   assign p = pp0 + (pp1 <<< 2);

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one combinational 4x4 signed Booth multiplier among NREQ
// requesters. A round-robin controller accepts one operand pair at a time,
// registers it into the multiplier, captures the product and returns it on
// a single response channel tagged with the requester id. One result per
// three cycles when the consumer is always ready.
module booth_mult_arbiter
   import booth_mult_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [OP_W*NREQ-1:0]   req_a,
   input  logic [OP_W*NREQ-1:0]   req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [PROD_W-1:0]      rsp_p,
   output logic                   busy,
   output logic [CNTW-1:0]        op_count
);

   state_t            state;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic [IDW-1:0]    cur_id;
   logic [IDW-1:0]    last_grant;
   logic [IDW-1:0]    grant;
   logic              any_valid;
   logic [OP_W-1:0]   sel_a;
   logic [OP_W-1:0]   sel_b;
   logic [PROD_W-1:0] prod;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .valid      (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .any_valid  (any_valid)
   );

   mbooth4bit u_mult (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   assign busy = (state != IDLE);

   // Only the granted requester sees ready, and only while the controller
   // is idle; the grant is recomputed every idle cycle.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = (state == IDLE) && any_valid && (grant == IDW'(i));
      end
   end

   // Route the granted requester's operand slices toward the operand registers.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            sel_a = req_a[OP_W*i +: OP_W];
            sel_b = req_b[OP_W*i +: OP_W];
         end
      end
   end

   // Controller: accept in IDLE, capture the product in MUL, hold the
   // response until the consumer takes it; reset drops any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         cur_id     <= '0;
         last_grant <= IDW'(NREQ - 1);
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_p      <= '0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  op_a       <= sel_a;
                  op_b       <= sel_b;
                  cur_id     <= grant;
                  last_grant <= grant;
                  state      <= MUL;
               end
            end
            MUL: begin
               rsp_p     <= prod;
               rsp_id    <= cur_id;
               rsp_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + CNTW'(1);
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter. A transaction-level model
// predicts each grant (round robin over valid requesters), the response
// timing and the product (plain signed multiply); accepted requests push
// their expected response into a queue that a separate monitor pops on
// every response handshake.
module tb_booth_mult_arbiter;

   localparam int NREQ = 3;
   localparam int IDW  = 2;
   localparam int CNTW = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [4*NREQ-1:0]   req_a;
   logic [4*NREQ-1:0]   req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [7:0]          rsp_p;
   logic                busy;
   logic [CNTW-1:0]     op_count;

   typedef struct {
      int id;
      int p;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   bit pending     = 1'b0;
   int acc_cyc     = 0;
   int cyc         = 0;
   int model_last  = NREQ - 1;
   int model_count = 0;
   int accepted    = -1;

   booth_mult_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW),
      .CNTW (CNTW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   function automatic int refProduct(input logic [3:0] a, input logic [3:0] b);
      int sa;
      int sbv;
      sa  = $signed(a);
      sbv = $signed(b);
      return (sa * sbv) & 255;
   endfunction

   function automatic int refPick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [4*NREQ-1:0] pack3(input int x0, input int x1, input int x2);
      return {4'(x2), 4'(x1), 4'(x0)};
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drive one cycle of inputs, check the outputs the model predicts for
   // this cycle, then advance the model across the following edge.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [4*NREQ-1:0] a,
                                input logic [4*NREQ-1:0] b, input logic rr);
      int   g;
      int   exp_ready;
      bit   exp_rv;
      exp_t e;
      @(negedge clk);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = rr;
      #1;
      exp_rv    = pending && (cyc >= acc_cyc + 2);
      g         = pending ? -1 : refPick(v, model_last);
      exp_ready = (g >= 0) ? (1 << g) : 0;
      checkOutput("req_ready", int'(req_ready), exp_ready);
      checkOutput("rsp_valid", int'(rsp_valid), int'(exp_rv));
      checkOutput("busy", int'(busy), int'(pending));
      checkOutput("op_count", int'(op_count), model_count % (1 << CNTW));
      if (exp_rv && sb.size() > 0) begin
         checkOutput("rsp_id_hold", int'(rsp_id), sb[0].id);
         checkOutput("rsp_p_hold", int'(rsp_p), sb[0].p);
      end
      accepted = -1;
      if (exp_rv && rr) begin
         pending = 1'b0;
         model_count++;
      end else if (g >= 0) begin
         pending    = 1'b1;
         acc_cyc    = cyc;
         model_last = g;
         accepted   = g;
         e.id       = g;
         e.p        = refProduct(a[4*g +: 4], b[4*g +: 4]);
         sb.push_back(e);
      end
      cyc++;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst         = 1'b0;
      pending     = 1'b0;
      model_last  = NREQ - 1;
      model_count = 0;
      sb.delete();
      #1;
      checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
      checkOutput("reset_rsp_id", int'(rsp_id), 0);
      checkOutput("reset_rsp_p", int'(rsp_p), 0);
      checkOutput("reset_op_count", int'(op_count), 0);
      checkOutput("reset_busy", int'(busy), 0);
   endtask

   // Present one request from requester id until accepted, then drain it.
   task automatic runOne(input int id, input int a, input int b);
      logic [NREQ-1:0]   v;
      logic [4*NREQ-1:0] va;
      logic [4*NREQ-1:0] vb;
      bit                done;
      v            = '0;
      v[id]        = 1'b1;
      va           = '0;
      vb           = '0;
      va[4*id +: 4] = 4'(a);
      vb[4*id +: 4] = 4'(b);
      done         = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         applyStimulus(v, va, vb, 1'b1);
         if (accepted == id) done = 1'b1;
      end
      checkOutput("accept_timeout", int'(done), 1);
      for (int k = 0; k < 10 && pending; k++) applyStimulus('0, '0, '0, 1'b1);
      checkOutput("drain_timeout", int'(pending), 0);
   endtask

   // Monitor: every response handshake must match the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checkOutput("rsp_unexpected", int'(rsp_valid), 0);
            end else begin
               e = sb.pop_front();
               checkOutput("sb_rsp_id", int'(rsp_id), e.id);
               checkOutput("sb_rsp_p", int'(rsp_p), e.p);
            end
         end
      end
   end

   initial begin
      logic [NREQ-1:0]   rv;
      logic [4*NREQ-1:0] ra;
      logic [4*NREQ-1:0] rb;
      logic              rr;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;

      doReset();

      // Reset while the multiply is in flight: response dropped, req0 first again.
      applyStimulus(3'b001, pack3(3, 0, 0), pack3(2, 0, 0), 1'b1);
      doReset();
      runOne(0, -7, 1);

      // Continuous contention between req0 and req1 alternates grants.
      doReset();
      for (int k = 0; k < 12; k++)
         applyStimulus(3'b011, pack3(5, 6, 0), pack3(-8, -6, 0), 1'b1);
      for (int k = 0; k < 10 && pending; k++) applyStimulus('0, '0, '0, 1'b1);

      // Backpressure on a held response while req0 waits.
      applyStimulus(3'b010, pack3(0, -1, 0), pack3(0, -1, 0), 1'b0);
      for (int k = 0; k < 6; k++)
         applyStimulus(3'b001, pack3(2, 0, 0), pack3(-3, 0, 0), 1'b0);
      applyStimulus(3'b001, pack3(2, 0, 0), pack3(-3, 0, 0), 1'b1);
      for (int k = 0; k < 10 && pending; k++) applyStimulus('0, '0, '0, 1'b1);

      // Operand extremes.
      runOne(0, -8, -8);
      runOne(1, 7, -8);
      runOne(2, -3, -1);

      // Counter wraps after four completions with a 2-bit counter.
      doReset();
      for (int k = 0; k < 5; k++) runOne(k % NREQ, k - 4, 3 - k);
      applyStimulus('0, '0, '0, 1'b1);

      // Randomized traffic honouring the hold-while-valid rule.
      rv = '0;
      ra = '0;
      rb = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] || accepted == i) begin
               rv[i] = 1'($urandom_range(0, 1));
               ra[4*i +: 4] = 4'($urandom);
               rb[4*i +: 4] = 4'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
               rv[i] = 1'b0;
            end
         end
         rr = ($urandom_range(0, 3) != 0);
         applyStimulus(rv, ra, rb, rr);
      end

      for (int k = 0; k < 20 && (pending || sb.size() > 0); k++)
         applyStimulus('0, '0, '0, 1'b1);
      checkOutput("sb_drain", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
